// File: rtl/game_pkg.sv
// Shared state encoding and button indices for the game-session controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WON  = 2'd2,
        BAD  = 2'd3
    } state_t;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_WRITE = 4;

endpackage

// File: rtl/btn_rise_detect.sv
// Per-button rising-edge detector; history resets high so held buttons
// must be released before they can register a press.
module btn_rise_detect #(
    parameter int NUM_BTN = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btnIn,
    output logic [NUM_BTN-1:0] rise,
    output logic               anyRise
);

    logic [NUM_BTN-1:0] btnPrev;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            btnPrev <= '1;
        end else begin
            btnPrev <= btnIn;
        end
    end

    assign rise    = btnIn & ~btnPrev;
    assign anyRise = |rise;

endmodule

// File: rtl/game_session_ctrl.sv
// Game-session sequencer IDLE -> PLAY -> WON -> IDLE with post-win hold-off.
// Optional GAME_TIMER_EN adds a saturating playTime counter.
module game_session_ctrl
    import game_pkg::*;
#(
    parameter int NUM_BTN     = 5,
    parameter int HOLDOFF_CYC = 4,
    parameter int CNT_W       = 8,
    parameter int TIME_W      = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               WinSig,
    input  logic [NUM_BTN-1:0] btnIn,
    output logic               gameStart,
    output logic               startPulse,
    output logic               winPulse,
    output logic [CNT_W-1:0]   gameCount,
    output logic [1:0]         state
`ifdef GAME_TIMER_EN
    ,
    output logic [TIME_W-1:0]  playTime
`endif
);

    localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_CYC - 1);

    state_t             st;
    logic [HW-1:0]      hold;
    logic [NUM_BTN-1:0] rise;
    logic               anyRise;
    logic               start;

    btn_rise_detect #(
        .NUM_BTN (NUM_BTN)
    ) u_rise (
        .CLK     (CLK),
        .RST     (RST),
        .btnIn   (btnIn),
        .rise    (rise),
        .anyRise (anyRise)
    );

    assign start = anyRise && (rise != '0);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            st         <= IDLE;
            gameStart  <= 1'b0;
            startPulse <= 1'b0;
            winPulse   <= 1'b0;
            gameCount  <= '0;
            hold       <= '0;
        end else begin
            startPulse <= 1'b0;
            winPulse   <= 1'b0;
            case (st)
                IDLE: begin
                    if (start) begin
                        st         <= PLAY;
                        gameStart  <= 1'b1;
                        startPulse <= 1'b1;
                    end
                end
                PLAY: begin
                    if (WinSig) begin
                        st        <= WON;
                        gameStart <= 1'b0;
                        winPulse  <= 1'b1;
                        hold      <= HOLD_INIT;
                        if (gameCount != '1)
                            gameCount <= gameCount + CNT_W'(1);
                    end
                end
                WON: begin
                    if (hold == '0)
                        st <= IDLE;
                    else
                        hold <= hold - HW'(1);
                end
                default: begin
                    st        <= IDLE;
                    gameStart <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

`ifdef GAME_TIMER_EN
    // Frozen outside PLAY so the last game's duration stays visible.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            playTime <= '0;
        end else if (st == IDLE && start) begin
            playTime <= '0;
        end else if (st == PLAY && playTime != '1) begin
            playTime <= playTime + TIME_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_game_session_ctrl.sv
// Directed scoreboard bench for game_session_ctrl (default parameters).
module tb_game_session_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WON  = 2'd2;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        WinSig = 1'b0;
    logic [4:0]  btnIn = 5'b0;
    logic        gameStart;
    logic        startPulse;
    logic        winPulse;
    logic [7:0]  gameCount;
    logic [1:0]  state;
`ifdef GAME_TIMER_EN
    logic [15:0] playTime;
`endif

    int checks = 0;
    int errors = 0;
    int cnt = 0;

    typedef struct {
        string       tag;
        logic [12:0] v;
    } exp_t;

    exp_t sb[$];

    game_session_ctrl #(
        .NUM_BTN     (5),
        .HOLDOFF_CYC (4),
        .CNT_W       (8),
        .TIME_W      (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .WinSig     (WinSig),
        .btnIn      (btnIn),
        .gameStart  (gameStart),
        .startPulse (startPulse),
        .winPulse   (winPulse),
        .gameCount  (gameCount),
        .state      (state)
`ifdef GAME_TIMER_EN
        ,
        .playTime   (playTime)
`endif
    );

    always #10 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic gs, input logic sp,
                        input logic wp, input logic [1:0] st);
        exp_t e;
        e.tag = tag;
        e.v   = {gs, sp, wp, st, 8'(cnt)};
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and compare against the queued result.
    task automatic cyc();
        exp_t e;
        @(negedge CLK);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.tag, 32'({gameStart, startPulse, winPulse, state, gameCount}),
                32'(e.v));
        end
    endtask

    task automatic drive(input logic [4:0] b, input logic w);
        btnIn  = b;
        WinSig = w;
    endtask

    // Win from PLAY, then the hold-off, then back to IDLE; btnIn held at b.
    task automatic win_seq(input logic [4:0] b);
        drive(b, 1'b1);
        cnt = (cnt < 255) ? cnt + 1 : 255;
        push("win", 0, 0, 1, S_WON);
        cyc();
        drive(b, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push("won_hold", 0, 0, 0, S_WON);
            cyc();
        end
        push("back_idle", 0, 0, 0, S_IDLE);
        cyc();
    endtask

    initial begin
        // Reset held for three cycles
        drive(5'b0, 1'b0);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("reset", 0, 0, 0, S_IDLE);
            cyc();
        end
        RST = 1'b1;
        push("idle", 0, 0, 0, S_IDLE);
        cyc();
        drive(5'b0, 1'b1);
        push("idle_winsig", 0, 0, 0, S_IDLE);
        cyc();
        drive(5'b0, 1'b0);
        push("idle_after", 0, 0, 0, S_IDLE);
        cyc();

        // One game started from each button
        for (int b = 0; b < 5; b++) begin
            drive(5'(1 << b), 1'b0);
            push("start", 1, 1, 0, S_PLAY);
            cyc();
            drive(5'b0, 1'b0);
            push("play", 1, 0, 0, S_PLAY);
            cyc();
            win_seq(5'b0);
        end
        chk("count_five", 32'(gameCount), 32'd5);

        // Button held from PLAY through WON into IDLE must not restart
        drive(5'b00001, 1'b0);
        push("held_start", 1, 1, 0, S_PLAY);
        cyc();
        push("held_play", 1, 0, 0, S_PLAY);
        cyc();
        win_seq(5'b00001);
        for (int i = 0; i < 3; i++) begin
            push("held_no_restart", 0, 0, 0, S_IDLE);
            cyc();
        end
        drive(5'b0, 1'b0);
        push("held_release", 0, 0, 0, S_IDLE);
        cyc();
        drive(5'b00001, 1'b0);
        push("held_repress", 1, 1, 0, S_PLAY);
        cyc();
        win_seq(5'b0);

        // Start and WinSig together: start taken, then a 1-cycle game
        drive(5'b00100, 1'b1);
        push("start_with_win", 1, 1, 0, S_PLAY);
        cyc();
        win_seq(5'b0);

        // Button held through reset
        RST = 1'b0;
        drive(5'b10000, 1'b0);
        cnt = 0;
        push("reset_held", 0, 0, 0, S_IDLE);
        cyc();
        push("reset_held", 0, 0, 0, S_IDLE);
        cyc();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("held_thru_reset", 0, 0, 0, S_IDLE);
            cyc();
        end
        drive(5'b0, 1'b0);
        push("rst_release", 0, 0, 0, S_IDLE);
        cyc();
        drive(5'b10000, 1'b0);
        push("rst_repress", 1, 1, 0, S_PLAY);
        cyc();
        win_seq(5'b0);

        // Saturate the games-won counter, then one more win
        while (cnt < 256) begin
            drive(5'b01000, 1'b1);
            push("sat_start", 1, 1, 0, S_PLAY);
            cyc();
            if (cnt == 255) begin
                win_seq(5'b0);
                break;
            end
            win_seq(5'b0);
        end
        chk("count_sat", 32'(gameCount), 32'd255);

        // Reset in the middle of a game, with WinSig present
        drive(5'b00010, 1'b0);
        push("mid_start", 1, 1, 0, S_PLAY);
        cyc();
        drive(5'b0, 1'b1);
        RST = 1'b0;
        cnt = 0;
        push("mid_reset", 0, 0, 0, S_IDLE);
        cyc();
        RST = 1'b1;
        drive(5'b0, 1'b0);
        push("mid_after", 0, 0, 0, S_IDLE);
        cyc();

`ifdef GAME_TIMER_EN
        drive(5'b00001, 1'b0);
        push("t_start", 1, 1, 0, S_PLAY);
        cyc();
        chk("t_clear0", 32'(playTime), 32'd0);
        drive(5'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            push("t_play", 1, 0, 0, S_PLAY);
            cyc();
        end
        win_seq(5'b0);
        chk("t_held10", 32'(playTime), 32'd10);
        cyc();
        chk("t_idle10", 32'(playTime), 32'd10);
        drive(5'b00001, 1'b0);
        cyc();
        chk("t_restart0", 32'(playTime), 32'd0);
        drive(5'b0, 1'b0);
        cyc();
        chk("t_count1", 32'(playTime), 32'd1);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_session_ctrl.md
Name: game_session_ctrl

Overview:
Parametrised game-session controller: generalised successor to the game-begin logic. Watches NUM_BTN player inputs (default up/down/left/right/write) plus WinSig and sequences IDLE -> PLAY -> WON -> IDLE.
- Rising-edge start detection.
- Post-win hold-off so a held button cannot immediately restart a game.
- One-cycle event pulses.
- Saturating games-won counter.
Sits between the input conditioning and the board/display logic; gameStart gates cursor movement and cell writes.

Parameters:
NUM_BTN, 5, number of player input lines (bit0 up, bit1 down, bit2 left, bit3 right, bit4 write); legal range >=1.
HOLDOFF_CYC, 4, cycles spent in WON before returning to IDLE; legal range >=1.
CNT_W, 8, width of gameCount.
TIME_W, 16, width of playTime (optional feature only).

Ports:
CLK  in  1  system clock, all logic on rising edge.
RST  in  1  reset, synchronous, active-low.
WinSig  in  1  board-solved indication, level, sampled each cycle.
btnIn  in  NUM_BTN  player inputs, already synchronised/debounced, active-high.
gameStart  out  1  high while state is PLAY.
startPulse  out  1  one-cycle pulse on IDLE->PLAY.
winPulse  out  1  one-cycle pulse on PLAY->WON.
gameCount  out  CNT_W  number of completed (won) games, saturating.
state  out  2  current state encoding (debug/display).
playTime  out  TIME_W  present only with GAME_TIMER_EN.

Behaviour:
- Reset (RST=0 at a CLK edge):
  - state=IDLE; gameStart=0, startPulse=0, winPulse=0, gameCount=0, holdoff counter=0.
  - btnPrev set to all ones, so a button held through reset must be released and re-pressed to start.
- Edge detect: rise = btnIn & ~btnPrev. btnPrev <= btnIn every cycle in every state, including WON.
- IDLE:
  - |rise -> PLAY. gameStart and startPulse are high in the cycle after the edge that sampled the rise (latency 1 clock).
  - WinSig is ignored in IDLE. If WinSig and a rise occur together, the start is taken.
- PLAY:
  - WinSig=1 -> WON. gameStart drops and winPulse=1 for one cycle. gameCount increments, holding at 2^CNT_W-1 if already saturated.
  - Button rises are ignored in PLAY.
  - WinSig asserted on the very first PLAY cycle is honoured, giving a 1-cycle game.
- WON:
  - Hold-off counter loaded with HOLDOFF_CYC-1 on entry and decremented each cycle. At 0 -> IDLE, so WON lasts exactly HOLDOFF_CYC cycles.
  - Rises and WinSig are ignored in WON.
  - A button that rose during WON and is still held does not start a game in IDLE, because btnPrev already shows it high.
- Illegal state 2'd3 -> IDLE next cycle, outputs as in IDLE.
- Pulses are registered and never high for two consecutive cycles.
- Reset mid-game: returns to IDLE on that edge. No winPulse and no count increment.

Optional Feature:
GAME_TIMER_EN:
- Defined: adds output playTime.
  - Cleared to 0 on the IDLE->PLAY transition.
  - Increments by 1 every cycle in PLAY, saturating at 2^TIME_W-1.
  - Frozen in WON and IDLE, so it shows the last game's duration.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package game_pkg:
  - state encoding IDLE=2'd0, PLAY=2'd1, WON=2'd2 (2'd3 illegal).
  - button-index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_WRITE=4.
- One sub-module: btn_rise_detect, parametrised by NUM_BTN. It holds btnPrev (reset all ones) and outputs the rise vector and its OR.

Test Plan:
All with NUM_BTN=5, HOLDOFF_CYC=4, CNT_W=8, 20 ns clock.
- Reset then idle: hold RST=0 3 cycles, release -> state=0, gameStart=0, gameCount=0; WinSig pulse in IDLE -> no change.
- Start/win per button: for each btnIn bit 0..4, pulse for 1 cycle, then WinSig 1 cycle.
  - Each start gives gameStart=1 one cycle later and startPulse exactly 1 cycle.
  - Each win gives winPulse 1 cycle, WON for 4 cycles, then IDLE.
  - gameCount ends at 5.
- Held button across win: hold btnIn=5'b00001 from PLAY through WON into IDLE -> no restart; release then press -> start.
- Held through reset: btnIn=5'b10000 during and after reset release -> stays IDLE until released and re-pressed.
- Saturation/reset mid-game:
  - Force 255 wins -> gameCount=255; 256th win -> stays 255.
  - RST=0 during PLAY -> IDLE, gameCount=0, no winPulse.
- GAME_TIMER_EN: start, WinSig after 10 PLAY cycles -> playTime=10 held in WON/IDLE; next start -> playTime clears to 0.
